pic_exec_ctrl: RTL and testbench

Instruction decode and execute sequencer for the PIC16C5x core. It sits directly upstream of the ALU. It latches each 12-bit instruction word from program memory and runs the four-phase Q1–Q4 cycle. It drives the ALU function, bit-select and literal inputs, plus the register-file, W, STATUS and PC control strobes. Two-cycle behaviour (skips, GOTO/CALL/RETLW) is handled by flushing the following fetched word into a forced NOP.

---
 rtl/pic_exec_ctrl_pkg.sv | 57 +++++
 rtl/pic_instr_decode.sv | 72 +++++++
 rtl/pic_exec_ctrl.sv | 149 ++++++++++++++
 tb/tb_pic_exec_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pic_exec_ctrl_pkg.sv
// pic_exec_ctrl_pkg
//   Shared constants for the PIC16C5x execute sequencer: bus widths, the
//   ALU function codes driven on aluFuncOut, phase encodings and the
//   instruction-class encodings produced by the decoder.
package pic_exec_ctrl_pkg;

    localparam int INSTR_WIDTH    = 12;
    localparam int PC_WIDTH       = 9;
    localparam int F_ADDR_WIDTH   = 5;
    localparam int ALU_FUNC_WIDTH = 5;

    // ALU function codes
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IDLE  = 5'd0;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ADDWF = 5'd1;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_SUBWF = 5'd2;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ANDWF = 5'd3;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IORWF = 5'd4;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_XORWF = 5'd5;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_COMF  = 5'd6;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_DECF  = 5'd7;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_INCF  = 5'd8;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_MOVF  = 5'd9;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_MOVWF = 5'd10;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_CLRF  = 5'd11;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_CLRW  = 5'd12;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_RLF   = 5'd13;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_RRF   = 5'd14;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_SWAPF = 5'd15;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BCF   = 5'd16;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_BSF   = 5'd17;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_ANDLW = 5'd18;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_IORLW = 5'd19;
    localparam logic [ALU_FUNC_WIDTH-1:0] ALU_XORLW = 5'd20;

    // Phase encodings (qOut)
    localparam logic [1:0] PH_Q1 = 2'd0;
    localparam logic [1:0] PH_Q2 = 2'd1;
    localparam logic [1:0] PH_Q3 = 2'd2;
    localparam logic [1:0] PH_Q4 = 2'd3;

    // Skip condition evaluated in Q3
    typedef enum logic [1:0] {
        SKIP_NONE = 2'd0,
        SKIP_ZERO = 2'd1,   // DECFSZ / INCFSZ: skip when result is zero
        SKIP_BCLR = 2'd2,   // BTFSC: skip when selected bit is clear
        SKIP_BSET = 2'd3    // BTFSS: skip when selected bit is set
    } skip_kind_e;

    // Two-cycle control transfers
    typedef enum logic [1:0] {
        BR_NONE  = 2'd0,
        BR_GOTO  = 2'd1,
        BR_CALL  = 2'd2,
        BR_RETLW = 2'd3
    } br_kind_e;

endpackage

// File: rtl/pic_instr_decode.sv
// pic_instr_decode
//   Purely combinational decode of a PIC16C5x 12-bit instruction word.
//   Ports:
//     irIn            instruction register contents
//     aluFuncOut      ALU function code
//     wWrOut/fWrOut   result destination (d bit on byte-file ops)
//     statusWrOut     instruction updates STATUS
//     skipKindOut     skip_kind_e class
//     brKindOut       br_kind_e class
//   SLEEP, CLRWDT, OPTION, TRIS and undefined words decode as NOP.
module pic_instr_decode
    import pic_exec_ctrl_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0]    irIn,
    output logic [ALU_FUNC_WIDTH-1:0] aluFuncOut,
    output logic                      wWrOut,
    output logic                      fWrOut,
    output logic                      statusWrOut,
    output logic [1:0]                skipKindOut,
    output logic [1:0]                brKindOut
);

    logic d_bit;
    assign d_bit = irIn[5];

    always_comb begin
        aluFuncOut  = ALU_IDLE;
        wWrOut      = 1'b0;
        fWrOut      = 1'b0;
        statusWrOut = 1'b0;
        skipKindOut = SKIP_NONE;
        brKindOut   = BR_NONE;
        casez (irIn)
            12'b0000_001?_????: begin aluFuncOut = ALU_MOVWF; fWrOut = 1'b1; end
            12'b0000_0100_0000: begin aluFuncOut = ALU_CLRW; wWrOut = 1'b1; statusWrOut = 1'b1; end
            12'b0000_011?_????: begin aluFuncOut = ALU_CLRF; fWrOut = 1'b1; statusWrOut = 1'b1; end
            12'b0000_10??_????: begin aluFuncOut = ALU_SUBWF; statusWrOut = 1'b1; end
            12'b0000_11??_????: begin aluFuncOut = ALU_DECF;  statusWrOut = 1'b1; end
            12'b0001_00??_????: begin aluFuncOut = ALU_IORWF; statusWrOut = 1'b1; end
            12'b0001_01??_????: begin aluFuncOut = ALU_ANDWF; statusWrOut = 1'b1; end
            12'b0001_10??_????: begin aluFuncOut = ALU_XORWF; statusWrOut = 1'b1; end
            12'b0001_11??_????: begin aluFuncOut = ALU_ADDWF; statusWrOut = 1'b1; end
            12'b0010_00??_????: begin aluFuncOut = ALU_MOVF;  statusWrOut = 1'b1; end
            12'b0010_01??_????: begin aluFuncOut = ALU_COMF;  statusWrOut = 1'b1; end
            12'b0010_10??_????: begin aluFuncOut = ALU_INCF;  statusWrOut = 1'b1; end
            12'b0010_11??_????: begin aluFuncOut = ALU_DECF;  skipKindOut = SKIP_ZERO; end
            12'b0011_00??_????: begin aluFuncOut = ALU_RRF;   statusWrOut = 1'b1; end
            12'b0011_01??_????: begin aluFuncOut = ALU_RLF;   statusWrOut = 1'b1; end
            12'b0011_10??_????: begin aluFuncOut = ALU_SWAPF; end
            12'b0011_11??_????: begin aluFuncOut = ALU_INCF;  skipKindOut = SKIP_ZERO; end
            12'b0100_????_????: begin aluFuncOut = ALU_BCF; fWrOut = 1'b1; end
            12'b0101_????_????: begin aluFuncOut = ALU_BSF; fWrOut = 1'b1; end
            12'b0110_????_????: skipKindOut = SKIP_BCLR;
            12'b0111_????_????: skipKindOut = SKIP_BSET;
            // RETLW/MOVLW pass the literal through IORLW; the datapath zeroes W for them
            12'b1000_????_????: begin aluFuncOut = ALU_IORLW; wWrOut = 1'b1; brKindOut = BR_RETLW; end
            12'b1001_????_????: brKindOut = BR_CALL;
            12'b101?_????_????: brKindOut = BR_GOTO;
            12'b1100_????_????: begin aluFuncOut = ALU_IORLW; wWrOut = 1'b1; end
            12'b1101_????_????: begin aluFuncOut = ALU_IORLW; wWrOut = 1'b1; statusWrOut = 1'b1; end
            12'b1110_????_????: begin aluFuncOut = ALU_ANDLW; wWrOut = 1'b1; statusWrOut = 1'b1; end
            12'b1111_????_????: begin aluFuncOut = ALU_XORLW; wWrOut = 1'b1; statusWrOut = 1'b1; end
            default: ;
        endcase
        // Byte-file ops (upper nibble 0..3, excluding MOVWF/CLRW/CLRF) steer by d
        if (irIn[11:10] == 2'b00 && irIn[9:7] != 3'b000) begin
            wWrOut = ~d_bit;
            fWrOut = d_bit;
        end
    end

endmodule

// File: rtl/pic_exec_ctrl.sv
// pic_exec_ctrl
//   Q1-Q4 phase sequencer and instruction register for the PIC16C5x core.
//   Ports:
//     clk, rst          core clock, synchronous active-high reset
//     instrIn           program word, latched on the Q4->Q1 edge
//     aluZeroIn, fBitIn skip inputs, sampled on the Q3->Q4 edge
//     qOut              current phase (0=Q1 .. 3=Q4)
//     aluFuncOut, bitSelOut, litOut, fAddrOut   decode held for the whole cycle
//     wWrEnOut, fWrEnOut, statusWrEnOut, pcLoadOut, stackPushOut,
//     stackPopOut       Q4 strobes; pcIncOut Q1 strobe
//     pcTargetOut       GOTO/CALL destination
//   A skip or branch flushes the following word into a forced NOP.
module pic_exec_ctrl
    import pic_exec_ctrl_pkg::*;
#(
    parameter int INSTR_WIDTH  = pic_exec_ctrl_pkg::INSTR_WIDTH,
    parameter int PC_WIDTH     = pic_exec_ctrl_pkg::PC_WIDTH,
    parameter int F_ADDR_WIDTH = pic_exec_ctrl_pkg::F_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INSTR_WIDTH-1:0]    instrIn,
    input  logic                      aluZeroIn,
    input  logic                      fBitIn,
    output logic [1:0]                qOut,
    output logic [ALU_FUNC_WIDTH-1:0] aluFuncOut,
    output logic [2:0]                bitSelOut,
    output logic [7:0]                litOut,
    output logic [F_ADDR_WIDTH-1:0]   fAddrOut,
    output logic                      wWrEnOut,
    output logic                      fWrEnOut,
    output logic                      statusWrEnOut,
    output logic                      pcIncOut,
    output logic                      pcLoadOut,
    output logic [PC_WIDTH-1:0]       pcTargetOut,
    output logic                      stackPushOut,
    output logic                      stackPopOut
);

    logic [1:0]             q_q, q_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   flush_q, flush_d;
    // Holds flush across the first fetch after reset so that word also runs as NOP
    logic                   fill_q, fill_d;
    logic                   skip_q, skip_d;
    logic                   w_wr_q, w_wr_d, f_wr_q, f_wr_d, st_wr_q, st_wr_d;
    logic                   pc_inc_q, pc_inc_d, pc_load_q, pc_load_d;
    logic                   push_q, push_d, pop_q, pop_d;

    logic [ALU_FUNC_WIDTH-1:0] dec_alu;
    logic                      dec_w, dec_f, dec_st;
    logic [1:0]                dec_skip, dec_br;
    logic                      live, skip_cond, in_q3;

    pic_instr_decode u_decode (
        .irIn        (ir_q),
        .aluFuncOut  (dec_alu),
        .wWrOut      (dec_w),
        .fWrOut      (dec_f),
        .statusWrOut (dec_st),
        .skipKindOut (dec_skip),
        .brKindOut   (dec_br)
    );

    assign live  = ~flush_q;
    assign in_q3 = (q_q == PH_Q3);

    always_comb begin
        skip_cond = 1'b0;
        case (dec_skip)
            SKIP_ZERO: skip_cond = aluZeroIn;
            SKIP_BCLR: skip_cond = ~fBitIn;
            SKIP_BSET: skip_cond = fBitIn;
            default:   skip_cond = 1'b0;
        endcase
    end

    // Next state: IR/flush advance only on the Q4->Q1 edge
    always_comb begin
        q_d     = q_q + 2'd1;
        ir_d    = ir_q;
        flush_d = flush_q;
        fill_d  = fill_q;
        skip_d  = skip_q;
        if (in_q3) begin
            skip_d = live & skip_cond;
        end
        if (q_q == PH_Q4) begin
            ir_d    = instrIn;
            flush_d = fill_q | (live & (skip_q | (dec_br != BR_NONE)));
            fill_d  = 1'b0;
        end
        // Strobes are registered one edge early so they appear exactly in Q4 / Q1
        w_wr_d    = in_q3 & live & dec_w;
        f_wr_d    = in_q3 & live & dec_f;
        st_wr_d   = in_q3 & live & dec_st;
        pc_load_d = in_q3 & live & (dec_br == BR_GOTO || dec_br == BR_CALL);
        push_d    = in_q3 & live & (dec_br == BR_CALL);
        pop_d     = in_q3 & live & (dec_br == BR_RETLW);
        pc_inc_d  = (q_q == PH_Q4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q       <= PH_Q4;
            ir_q      <= '0;
            flush_q   <= 1'b1;
            fill_q    <= 1'b1;
            skip_q    <= 1'b0;
            w_wr_q    <= 1'b0;
            f_wr_q    <= 1'b0;
            st_wr_q   <= 1'b0;
            pc_inc_q  <= 1'b0;
            pc_load_q <= 1'b0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
        end else begin
            q_q       <= q_d;
            ir_q      <= ir_d;
            flush_q   <= flush_d;
            fill_q    <= fill_d;
            skip_q    <= skip_d;
            w_wr_q    <= w_wr_d;
            f_wr_q    <= f_wr_d;
            st_wr_q   <= st_wr_d;
            pc_inc_q  <= pc_inc_d;
            pc_load_q <= pc_load_d;
            push_q    <= push_d;
            pop_q     <= pop_d;
        end
    end

    assign qOut          = q_q;
    assign aluFuncOut    = live ? dec_alu : ALU_IDLE;
    assign bitSelOut     = ir_q[7:5];
    assign litOut        = ir_q[7:0];
    assign fAddrOut      = ir_q[F_ADDR_WIDTH-1:0];
    // CALL can only reach the lower half page; the PC block clears PC[8]
    assign pcTargetOut   = (dec_br == BR_CALL) ? {{(PC_WIDTH-8){1'b0}}, ir_q[7:0]}
                                               : ir_q[PC_WIDTH-1:0];
    assign wWrEnOut      = w_wr_q;
    assign fWrEnOut      = f_wr_q;
    assign statusWrEnOut = st_wr_q;
    assign pcIncOut      = pc_inc_q;
    assign pcLoadOut     = pc_load_q;
    assign stackPushOut  = push_q;
    assign stackPopOut   = pop_q;

endmodule

// File: tb/tb_pic_exec_ctrl.sv
// tb_pic_exec_ctrl
//   Scoreboard bench: each issued instruction pushes its four per-phase
//   expected output records; a monitor pops and compares one record per clock.
module tb_pic_exec_ctrl;
    import pic_exec_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] instrIn = '0;
    logic        aluZeroIn = 1'b0;
    logic        fBitIn = 1'b0;
    logic [1:0]  qOut;
    logic [4:0]  aluFuncOut;
    logic [2:0]  bitSelOut;
    logic [7:0]  litOut;
    logic [4:0]  fAddrOut;
    logic        wWrEnOut, fWrEnOut, statusWrEnOut, pcIncOut, pcLoadOut;
    logic [8:0]  pcTargetOut;
    logic        stackPushOut, stackPopOut;

    pic_exec_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .instrIn       (instrIn),
        .aluZeroIn     (aluZeroIn),
        .fBitIn        (fBitIn),
        .qOut          (qOut),
        .aluFuncOut    (aluFuncOut),
        .bitSelOut     (bitSelOut),
        .litOut        (litOut),
        .fAddrOut      (fAddrOut),
        .wWrEnOut      (wWrEnOut),
        .fWrEnOut      (fWrEnOut),
        .statusWrEnOut (statusWrEnOut),
        .pcIncOut      (pcIncOut),
        .pcLoadOut     (pcLoadOut),
        .pcTargetOut   (pcTargetOut),
        .stackPushOut  (stackPushOut),
        .stackPopOut   (stackPopOut)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] q;
        logic [4:0] alu;
        logic [2:0] bs;
        logic [7:0] lit;
        logic [4:0] fa;
        logic       w, f, st, inc, ld;
        logic [8:0] tgt;
        logic       ps, pp;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic push_reset(input string nm);
        obs_t e;
        e     = '0;
        e.q   = 2'd3;
        e.alu = ALU_IDLE;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Push n per-phase records for one instruction (Q1 first).
    task automatic push_instr(input string nm, input logic [11:0] word,
                              input logic [4:0] alu, input logic w, input logic f,
                              input logic st, input logic ld, input logic ps,
                              input logic pp, input logic [8:0] tgt, input int n);
        for (int p = 0; p < n; p++) begin
            obs_t e;
            e     = '0;
            e.q   = p[1:0];
            e.alu = alu;
            e.bs  = word[7:5];
            e.lit = word[7:0];
            e.fa  = word[4:0];
            e.tgt = tgt;
            if (p == 0) e.inc = 1'b1;
            if (p == 3) begin
                e.w  = w;  e.f  = f;  e.st = st;
                e.ld = ld; e.ps = ps; e.pp = pp;
            end
            exp_q.push_back(e);
            name_q.push_back($sformatf("%s.Q%0d", nm, p + 1));
        end
    endtask

    // Called at the negedge of a Q4 cycle; returns at the negedge of the next Q4.
    task automatic issue(input string nm, input logic [11:0] word, input logic zin,
                         input logic fin, input logic [4:0] alu, input logic w,
                         input logic f, input logic st, input logic ld, input logic ps,
                         input logic pp, input logic [8:0] tgt);
        instrIn   = word;
        aluZeroIn = zin;
        fBitIn    = fin;
        push_instr(nm, word, alu, w, f, st, ld, ps, pp, tgt, 4);
        repeat (4) @(negedge clk);
    endtask

    // Monitor: one record per clock, sampled mid-cycle
    initial begin
        obs_t  act, e;
        string nm;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                act = {qOut, aluFuncOut, bitSelOut, litOut, fAddrOut, wWrEnOut,
                       fWrEnOut, statusWrEnOut, pcIncOut, pcLoadOut, pcTargetOut,
                       stackPushOut, stackPopOut};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_cycle act=%h required=<no record>", act);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL %s act q=%0d alu=%0d bs=%0d lit=%h fa=%h w%0b f%0b st%0b inc%0b ld%0b tgt=%h ps%0b pp%0b | required q=%0d alu=%0d bs=%0d lit=%h fa=%h w%0b f%0b st%0b inc%0b ld%0b tgt=%h ps%0b pp%0b",
                                 nm, act.q, act.alu, act.bs, act.lit, act.fa, act.w, act.f,
                                 act.st, act.inc, act.ld, act.tgt, act.ps, act.pp,
                                 e.q, e.alu, e.bs, e.lit, e.fa, e.w, e.f, e.st, e.inc,
                                 e.ld, e.tgt, e.ps, e.pp);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        push_reset("reset");
        rst = 1'b0;
        //      name        word    z  b  alu        w  f  st ld ps pp tgt
        issue("fill",      12'h1E7, 0, 0, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h1E7);
        issue("addwf_f",   12'h1E7, 0, 0, ALU_ADDWF, 0, 1, 1, 0, 0, 0, 9'h1E7);
        // 0x1C7 carries IR[5]=0, so the result goes to W
        issue("addwf_w",   12'h1C7, 0, 0, ALU_ADDWF, 1, 0, 1, 0, 0, 0, 9'h1C7);
        issue("bsf",       12'h5A3, 0, 0, ALU_BSF,   0, 1, 0, 0, 0, 0, 9'h1A3);
        issue("decfsz_z1", 12'h2E4, 1, 0, ALU_DECF,  0, 1, 0, 0, 0, 0, 9'h0E4);
        issue("skipped",   12'h1E7, 0, 0, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h1E7);
        issue("after_skp", 12'h1E7, 0, 0, ALU_ADDWF, 0, 1, 1, 0, 0, 0, 9'h1E7);
        issue("decfsz_z0", 12'h2E4, 0, 0, ALU_DECF,  0, 1, 0, 0, 0, 0, 9'h0E4);
        issue("movlw",     12'hC3A, 0, 0, ALU_IORLW, 1, 0, 0, 0, 0, 0, 9'h03A);
        issue("btfsc_b0",  12'h6A3, 0, 0, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h0A3);
        issue("goto_fl",   12'hA55, 0, 0, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h055);
        issue("goto",      12'hA55, 0, 0, ALU_IDLE,  0, 0, 0, 1, 0, 0, 9'h055);
        issue("goto_b2b",  12'hA12, 0, 0, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h012);
        issue("btfss_b1",  12'h7A3, 0, 1, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h1A3);
        issue("andlw_fl1", 12'hE0F, 0, 0, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h00F);
        issue("call",      12'h9C8, 0, 0, ALU_IDLE,  0, 0, 0, 1, 1, 0, 9'h0C8);
        issue("andlw_fl2", 12'hE0F, 0, 0, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h00F);
        issue("retlw",     12'h855, 0, 0, ALU_IORLW, 1, 0, 0, 0, 0, 1, 9'h055);
        issue("andlw_fl3", 12'hE0F, 0, 0, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h00F);
        issue("andlw",     12'hE0F, 0, 0, ALU_ANDLW, 1, 0, 1, 0, 0, 0, 9'h00F);
        issue("swapf",     12'h3A1, 0, 0, ALU_SWAPF, 0, 1, 0, 0, 0, 0, 9'h1A1);
        issue("btfss_b0",  12'h7A3, 0, 0, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h1A3);
        issue("addwf_ok",  12'h1E7, 0, 0, ALU_ADDWF, 0, 1, 1, 0, 0, 0, 9'h1E7);

        // Reset asserted during Q3 of an ADDWF: only Q1..Q3 are seen, then reset state
        instrIn = 12'h1E7;
        push_instr("addwf_rst", 12'h1E7, ALU_ADDWF, 0, 1, 1, 0, 0, 0, 9'h1E7, 3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        push_reset("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        issue("fill2",     12'h1E7, 0, 0, ALU_IDLE,  0, 0, 0, 0, 0, 0, 9'h1E7);
        issue("addwf_w2",  12'h1C7, 0, 0, ALU_ADDWF, 1, 0, 1, 0, 0, 0, 9'h1C7);

        #2;
        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_records act=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
